// File: rtl/wo_reg_pkg.sv
// Shared definitions for the write-once register arbiter: the arbiter FSM
// state encoding and the position of the lock bit inside each register word.
package wo_reg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    // Bit 0 of every register word mirrors that register's lock flag.
    localparam int LOCK_BIT = 0;

endpackage

// File: rtl/wo_reg_arbiter_if.sv
// Requester-side bus of the write-once register arbiter: per-requester
// request/index/data going in, grant/done/error pulses coming back.
// Requester i owns bit i of req/gnt/done/err and slice i of addr/wdata.
interface wo_reg_arbiter_if #(
    parameter int NREQ = 2,
    parameter int AW   = 2,
    parameter int DW   = 16
);

    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    done;
    logic [NREQ-1:0]    err;

    modport master (
        output req, addr, wdata,
        input  gnt, done, err
    );

    modport slave (
        input  req, addr, wdata,
        output gnt, done, err
    );

endinterface

// File: rtl/wo_reg_cell.sv
// One write-once bank entry: a data word plus a sticky lock flag. Once the
// lock is set the entry ignores further writes until reset. The stored data
// keeps the lock position at zero; the output merges the lock flag back in so
// bit LOCK_BIT always reads as the lock.
module wo_reg_cell
    import wo_reg_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic          Clk,
    input  logic          ip_resetn,
    input  logic          we,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] data_out,
    output logic          locked
);

    localparam logic [DW-1:0] LOCK_MASK = DW'(1) << LOCK_BIT;

    logic [DW-1:0] data_q;
    logic          lock_q;

    // Load data and lock on an accepted write; a locked cell protects itself.
    // NOTE: the bank is a handful of control-visible registers, not a RAM, so
    // it is reset; unlocked-at-zero after reset is part of its contract.
    always_ff @(posedge Clk or negedge ip_resetn) begin
        if (!ip_resetn) begin
            data_q <= '0;
            lock_q <= 1'b0;
        end else if (we && !lock_q) begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge values, independent of statement order.
            data_q <= wdata & ~LOCK_MASK;
            lock_q <= wdata[LOCK_BIT];
        end
    end

    assign data_out = data_q | (lock_q ? LOCK_MASK : '0);
    assign locked   = lock_q;

endmodule

// File: rtl/wo_reg_arbiter.sv
// Round-robin arbiter in front of a bank of write-once registers.
// Each transaction walks IDLE -> GRANT -> WRITE -> RESP -> IDLE. A write to a
// locked or non-existent register is dropped; with WO_ARB_ERR_RESP_EN defined
// it is reported on err together with done, otherwise err stays 0 and the
// rejected write completes silently.
module wo_reg_arbiter
    import wo_reg_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int NREG = 4,
    parameter int DW   = 16,
    parameter int AW   = 2
) (
    input  logic                Clk,
    input  logic                ip_resetn,
    wo_reg_arbiter_if.slave     bus,
    output logic [NREG*DW-1:0]  reg_out,
    output logic [NREG-1:0]     lock_status
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_e      state_q, state_d;
    logic [IW-1:0]   win_q, win_d;
    logic [IW-1:0]   last_q, last_d;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;

    logic [IW-1:0]   rr_sel;
    logic [IW-1:0]   rr_idx;
    logic            rr_any;
    logic [NREQ-1:0] win_oh;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic            target_valid;
    logic            target_locked;
    logic            wr_ok;
    logic [NREG-1:0] cell_we;
    logic [NREQ-1:0] gnt_c;
    logic [NREQ-1:0] done_c;

    // Round-robin pick: first requester at or after the one following last_q.
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        rr_sel = '0;
        rr_idx = '0;
        rr_any = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            rr_idx = IW'((int'(last_q) + k) % NREQ);
            if (!rr_any && bus.req[rr_idx]) begin
                rr_any = 1'b1;
                rr_sel = rr_idx;
            end
        end
    end

    // Decode the current winner into a one-hot vector and its bus slices.
    always_comb begin
        win_oh    = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_q == IW'(i)) begin
                win_oh[i] = 1'b1;
                sel_addr  = bus.addr[i*AW +: AW];
                sel_wdata = bus.wdata[i*DW +: DW];
            end
        end
    end

    // Qualify the captured target: it must exist and be unlocked.
    always_comb begin
        target_valid  = (int'(addr_q) < NREG);
        target_locked = 1'b0;
        cell_we       = '0;
        for (int i = 0; i < NREG; i++) begin
            if (addr_q == AW'(i)) begin
                target_locked = lock_status[i];
            end
        end
        wr_ok = target_valid && !target_locked;
        for (int i = 0; i < NREG; i++) begin
            cell_we[i] = (state_q == ST_WRITE) && wr_ok && (addr_q == AW'(i));
        end
    end

    // Next state, grant and done. A winner whose req has dropped by GRANT is
    // withdrawn: no grant, no write, and the round-robin pointer stays put.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        last_d  = last_q;
        gnt_c   = '0;
        done_c  = '0;
        case (state_q)
            ST_IDLE: begin
                if (rr_any) begin
                    win_d   = rr_sel;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (bus.req[win_q]) begin
                    gnt_c   = win_oh;
                    last_d  = win_q;
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: state_d = ST_RESP;
            ST_RESP: begin
                done_c  = win_oh;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state, winner and round-robin pointer; reset makes requester 0 win first.
    always_ff @(posedge Clk or negedge ip_resetn) begin
        if (!ip_resetn) begin
            state_q <= ST_IDLE;
            win_q   <= '0;
            last_q  <= IW'(NREQ - 1);
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            last_q  <= last_d;
        end
    end

    // Capture the granted requester's index and data during GRANT.
    always_ff @(posedge Clk or negedge ip_resetn) begin
        if (!ip_resetn) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (state_q == ST_GRANT && bus.req[win_q]) begin
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
        end
    end

    assign bus.gnt  = gnt_c;
    assign bus.done = done_c;

`ifdef WO_ARB_ERR_RESP_EN
    logic err_flag_q;

    // Remember during WRITE whether the write was rejected, for the RESP pulse.
    always_ff @(posedge Clk or negedge ip_resetn) begin
        if (!ip_resetn) begin
            err_flag_q <= 1'b0;
        end else if (state_q == ST_WRITE) begin
            err_flag_q <= !wr_ok;
        end
    end

    assign bus.err = (state_q == ST_RESP && err_flag_q) ? win_oh : '0;
`else
    assign bus.err = '0;
`endif

    for (genvar i = 0; i < NREG; i++) begin : g_cell
        wo_reg_cell #(
            .DW (DW)
        ) u_cell (
            .Clk       (Clk),
            .ip_resetn (ip_resetn),
            .we        (cell_we[i]),
            .wdata     (wdata_q),
            .data_out  (reg_out[i*DW +: DW]),
            .locked    (lock_status[i])
        );
    end

endmodule

// File: tb/tb_wo_reg_arbiter.sv
// Scoreboard bench for wo_reg_arbiter: stimulus pushes expected grants and
// responses into queues; a negedge monitor pops and compares whenever the
// DUT pulses gnt or done.
module tb_wo_reg_arbiter;

    localparam int NREQ = 2;
    localparam int NREG = 4;
    localparam int DW   = 16;
    localparam int AW   = 2;

`ifdef WO_ARB_ERR_RESP_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        int            who;
        logic          err;
        int            addr;
        logic [DW-1:0] val;
        logic          lock;
    } rsp_t;

    logic Clk = 1'b0;
    logic ip_resetn;
    logic [NREG*DW-1:0] reg_out;
    logic [NREG-1:0]    lock_status;

    wo_reg_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    wo_reg_arbiter #(
        .NREQ (NREQ),
        .NREG (NREG),
        .DW   (DW),
        .AW   (AW)
    ) dut (
        .Clk         (Clk),
        .ip_resetn   (ip_resetn),
        .bus         (bus),
        .reg_out     (reg_out),
        .lock_status (lock_status)
    );

    always #5 Clk = ~Clk;

    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_gnt_q[$];
    rsp_t exp_rsp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compare every grant/done pulse with the head of its queue.
    int   mon_w;
    rsp_t mon_r;
    always @(negedge Clk) begin
        if (ip_resetn) begin
            if (bus.gnt != '0) begin
                if (exp_gnt_q.size() == 0) begin
                    check("gnt_unexpected", 64'(bus.gnt), 64'd0);
                end else begin
                    mon_w = exp_gnt_q.pop_front();
                    check("gnt_who", 64'(bus.gnt), 64'd1 << mon_w);
                end
            end
            if (bus.done != '0) begin
                if (exp_rsp_q.size() == 0) begin
                    check("done_unexpected", 64'(bus.done), 64'd0);
                end else begin
                    mon_r = exp_rsp_q.pop_front();
                    check("done_who", 64'(bus.done), 64'd1 << mon_r.who);
                    check("err_resp", 64'(bus.err), mon_r.err ? (64'd1 << mon_r.who) : 64'd0);
                    check("reg_val", 64'(reg_out[mon_r.addr*DW +: DW]), 64'(mon_r.val));
                    check("lock_bit", 64'(lock_status[mon_r.addr]), 64'(mon_r.lock));
                end
            end else if (bus.err != '0) begin
                check("err_without_done", 64'(bus.err), 64'd0);
            end
        end
    end

    // One complete write from requester `who`; returns grant and done latencies.
    task automatic txn(input int who, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic e, input logic [DW-1:0] v, input logic l,
                       output int gl, output int dl);
        exp_gnt_q.push_back(who);
        exp_rsp_q.push_back('{who: who, err: e, addr: int'(a), val: v, lock: l});
        bus.addr[who*AW +: AW]  = a;
        bus.wdata[who*DW +: DW] = d;
        bus.req[who]            = 1'b1;
        gl = 0;
        dl = 0;
        while (gl < 20) begin
            @(negedge Clk);
            gl++;
            if (bus.gnt[who]) break;
        end
        if (!bus.gnt[who]) begin
            check("gnt_timeout", 64'(gl), 64'd0);
            bus.req[who] = 1'b0;
            return;
        end
        @(posedge Clk);
        #1 bus.req[who] = 1'b0;
        while (dl < 20) begin
            @(negedge Clk);
            dl++;
            if (bus.done[who]) break;
        end
        if (!bus.done[who]) check("done_timeout", 64'(dl), 64'd0);
    endtask

    initial begin
        int gl, dl, n, t, last_t;
        bus.req   = '0;
        bus.addr  = '0;
        bus.wdata = '0;
        ip_resetn = 1'b0;

        // Reset state
        #1;
        check("rst_gnt", 64'(bus.gnt), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_err", 64'(bus.err), 64'd0);
        check("rst_reg_out", 64'(reg_out), 64'd0);
        check("rst_lock", 64'(lock_status), 64'd0);
        repeat (2) @(negedge Clk);
        ip_resetn = 1'b1;

        // First write locks register 2: grant one cycle, done two more later
        txn(0, 2'd2, 16'h1235, 1'b0, 16'h1235, 1'b1, gl, dl);
        check("lat_gnt", 64'(gl), 64'd1);
        check("lat_done", 64'(dl), 64'd2);

        // Write to the locked register is rejected
        txn(1, 2'd2, 16'hAAAA, ERR_EN, 16'h1235, 1'b1, gl, dl);
        check("locked_reg2", 64'(reg_out[2*DW +: DW]), 64'h1235);

        // Both requesting continuously: grants alternate 0,1,0,1 every 4 cycles
        for (int k = 0; k < 4; k++) begin
            exp_gnt_q.push_back(k % 2);
            if (k % 2 == 0)
                exp_rsp_q.push_back('{who: 0, err: 1'b0, addr: 0, val: 16'h0F00, lock: 1'b0});
            else
                exp_rsp_q.push_back('{who: 1, err: 1'b0, addr: 3, val: 16'h5550, lock: 1'b0});
        end
        bus.addr  = {2'd3, 2'd0};
        bus.wdata = {16'h5550, 16'h0F00};
        bus.req   = 2'b11;
        n = 0;
        t = 0;
        last_t = -1;
        while (n < 4 && t < 60) begin
            @(negedge Clk);
            t++;
            if (bus.gnt != '0) begin
                if (last_t >= 0) check("rr_spacing", 64'(t - last_t), 64'd4);
                last_t = t;
                n++;
                if (n == 4) begin
                    @(posedge Clk);
                    #1 bus.req = '0;
                end
            end
        end
        check("rr_grant_count", 64'(n), 64'd4);
        repeat (6) @(negedge Clk);

        // One-cycle req[1] pulse while requester 0 is being served is ignored
        exp_gnt_q.push_back(0);
        exp_rsp_q.push_back('{who: 0, err: 1'b0, addr: 3, val: 16'h7770, lock: 1'b0});
        bus.addr[0*AW +: AW]  = 2'd3;
        bus.wdata[0*DW +: DW] = 16'h7770;
        bus.req[0] = 1'b1;
        gl = 0;
        while (gl < 20 && !bus.gnt[0]) begin
            @(negedge Clk);
            gl++;
        end
        if (!bus.gnt[0]) check("pulse_gnt_timeout", 64'(gl), 64'd0);
        @(posedge Clk);
        #1;
        bus.req[0] = 1'b0;
        bus.addr[1*AW +: AW]  = 2'd3;
        bus.wdata[1*DW +: DW] = 16'hFFFF;
        bus.req[1] = 1'b1;
        @(posedge Clk);
        #1 bus.req[1] = 1'b0;
        repeat (8) @(negedge Clk);
        check("pulse_reg3", 64'(reg_out[3*DW +: DW]), 64'h7770);
        check("pulse_lock3", 64'(lock_status[3]), 64'd0);

        // Reset during WRITE aborts the write and clears everything at once
        exp_gnt_q.push_back(0);
        bus.addr[0*AW +: AW]  = 2'd1;
        bus.wdata[0*DW +: DW] = 16'h00F1;
        bus.req[0] = 1'b1;
        gl = 0;
        while (gl < 20 && !bus.gnt[0]) begin
            @(negedge Clk);
            gl++;
        end
        if (!bus.gnt[0]) check("abort_gnt_timeout", 64'(gl), 64'd0);
        @(posedge Clk);
        #1;
        bus.req[0] = 1'b0;
        ip_resetn  = 1'b0;
        #1;
        check("abort_gnt", 64'(bus.gnt), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_err", 64'(bus.err), 64'd0);
        check("abort_reg_out", 64'(reg_out), 64'd0);
        check("abort_lock", 64'(lock_status), 64'd0);
        repeat (2) @(negedge Clk);
        ip_resetn = 1'b1;
        repeat (6) @(negedge Clk);
        check("abort_reg1", 64'(reg_out[1*DW +: DW]), 64'd0);

        // After reset the pointer favours requester 0 even with both requesting
        bus.addr[1*AW +: AW]  = 2'd2;
        bus.wdata[1*DW +: DW] = 16'h1234;
        bus.req[1] = 1'b1;
        txn(0, 2'd1, 16'hBEEF, 1'b0, 16'hBEEF, 1'b1, gl, dl);
        txn(1, 2'd2, 16'h1234, 1'b0, 16'h1234, 1'b0, gl, dl);
        repeat (4) @(negedge Clk);

        check("final_reg_out", 64'(reg_out), 64'h0000_1234_BEEF_0000);
        check("final_lock", 64'(lock_status), 64'b0010);
        check("gnt_queue_drained", 64'(exp_gnt_q.size()), 64'd0);
        check("rsp_queue_drained", 64'(exp_rsp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/wo_reg_arbiter.md
WO_REG_ARBITER -- requirements
Module: wo_reg_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 2, number of requesters.
REQ-002 SHALL have parameter NREG, default 4, number of write-once registers in the bank.
REQ-003 SHALL have parameter DW, default 16, register data width.
REQ-004 SHALL have parameter AW, default 2, register index width (clog2 of NREG).
REQ-005 SHALL have port Clk  input  1  single clock; all state on its rising edge.
REQ-006 SHALL have port ip_resetn  input  1  asynchronous active-low reset.
REQ-007 SHALL have port req  input  NREQ  per-requester write request, level, held until gnt.
REQ-008 SHALL have port addr  input  NREQ*AW  per-requester register index, slice i for requester i.
REQ-009 SHALL have port wdata  input  NREQ*DW  per-requester write data; bit 0 is the lock request.
REQ-010 SHALL have port gnt  output  NREQ  one-cycle grant pulse, one-hot or zero.
REQ-011 SHALL have port done  output  NREQ  one-cycle completion pulse to the granted requester.
REQ-012 SHALL have port err  output  NREQ  one-cycle pulse with done when the target register is locked.
REQ-013 SHALL have port reg_out  output  NREG*DW  current value of every bank register.
REQ-014 SHALL have port lock_status  output  NREG  lock bit of every bank register.

Function
REQ-015 SHALL implement FSM IDLE -> GRANT -> WRITE -> RESP -> IDLE, one cycle per non-IDLE state.
REQ-016 In IDLE with any req high, SHALL select the winner round-robin, starting from the index after the last granted one, and move to GRANT.
REQ-017 In GRANT, SHALL pulse gnt[winner] and capture addr and wdata of the winner.
REQ-018 In WRITE with target unlocked, SHALL load register with wdata & ~1 and set lock to wdata[0].
REQ-019 In WRITE with target locked, SHALL leave register and lock unchanged and flag error.
REQ-020 In RESP, SHALL pulse done[winner] and, if flagged, err[winner]; then return to IDLE.
REQ-021 Latency: req sampled high at edge N -> gnt high in cycle N+1, done in cycle N+3; next grant no earlier than cycle N+5.
REQ-022 A req dropped before its gnt SHALL be treated as withdrawn; no write occurs.
REQ-023 req held high after gnt SHALL be treated as a new request.
REQ-024 addr >= NREG SHALL cause no write and SHALL set err.
REQ-025 Register bit 0 SHALL always read as the lock bit (reg_out[i*DW] == lock_status[i]).
REQ-026 Locks SHALL clear only by reset.

Reset
REQ-027 ip_resetn low SHALL immediately force: FSM IDLE, gnt/done/err 0, all registers and locks 0, round-robin pointer so requester 0 wins first.
REQ-028 Reset in GRANT or WRITE SHALL abort with no register update and no done.

Configuration
REQ-029 With WO_ARB_ERR_RESP_EN defined, err SHALL behave per REQ-012/019/024.
REQ-030 Without WO_ARB_ERR_RESP_EN, err SHALL be tied 0; rejected writes complete silently with done only.

Structure
REQ-031 Shared package wo_reg_pkg SHALL hold the FSM state enum and the lock bit position constant (0).
REQ-032 Each bank entry SHALL be a sub-module wo_reg_cell (data + lock, write-enable, locked output), instantiated NREG times.

Verification
REQ-033 Reset release, req[0]=1, addr=2, wdata=16'h1235 -> gnt[0] cycle 1, done[0] cycle 3, reg_out[2]=16'h1235, lock_status[2]=1, err=0.
REQ-034 After REQ-033, req[1]=1, addr=2, wdata=16'hAAAA -> done[1] and err[1] pulse, reg_out[2] stays 16'h1235.
REQ-035 req=2'b11 held continuously, wdata bit0=0 -> grants alternate 0,1,0,1 every 4 cycles.
REQ-036 req[0]=1 with addr=1, ip_resetn low during WRITE -> all outputs 0, reg_out[1]=0, no done.
REQ-037 Build without WO_ARB_ERR_RESP_EN, repeat REQ-034 -> done[1] pulses, err stays 0, reg_out[2] unchanged.
REQ-038 req[1] pulsed one cycle while FSM busy on requester 0 -> no gnt[1], no write.
